// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared FSM states, command constants and frame-length helper for the SPI ADC scanner
package adc_spi_pkg;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;
  localparam logic CMD_START = 1'b1;
  localparam logic CMD_SGL = 1'b1;
  function automatic int frame_len(input int ch_w, input int null_bits, input int data_w);
    return 2 + ch_w + null_bits + data_w;
  endfunction
endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: divides clk into a 50% sclk with one-cycle rise/fall strobes while enabled
module adc_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(2 * CLK_DIV);
  logic [W-1:0] cg;
  assign rise = en && cg == '0;
  assign fall = en && cg == W'(CLK_DIV);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cg <= '0;
      sclk <= 1'b0;
    end else begin
      cg <= (!en || cg == W'(2 * CLK_DIV - 1)) ? '0 : cg + 1'b1;
      sclk <= rise ? 1'b1 : fall ? 1'b0 : sclk && en;
    end
endmodule

// File: rtl/adc_spi_scanner.sv
// adc_spi_scanner: scans a channel mask on a multi-channel SPI ADC and streams tagged results
module adc_spi_scanner
  import adc_spi_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int NULL_BITS = 3,
  parameter int NUM_CH = 8,
  parameter int CLK_DIV = 4,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              adc_miso,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              adc_mosi,
  output logic              busy,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              overrun
);
  localparam int CMD_W = 2 + CH_W;
  localparam int FL = frame_len(CH_W, NULL_BITS, DATA_W);
  localparam int SKIP = CMD_W + NULL_BITS;
  localparam int SHIFT_CYC = 2 * CLK_DIV * FL;
  localparam int CNT_W = $clog2(SHIFT_CYC);
  localparam int RC_W = $clog2(FL + 1);
  state_t st;
  logic [CNT_W-1:0] cnt;
  logic [NUM_CH-1:0] mask_q;
  logic [CH_W-1:0] ch, nxt_ch, lo_ch, st_ch;
  logic nxt_found, sclk_en, rise, fall;
  logic [CMD_W-1:0] sr;
  logic [RC_W-1:0] rc;
  logic [DATA_W-1:0] sh;
  function automatic logic [CMD_W-1:0] cmd(input logic [CH_W-1:0] c);
    return {CMD_START, CMD_SGL, c};
  endfunction
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch = '0;
    lo_ch = '0;
    st_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && CH_W'(i) > ch) begin
        nxt_found = 1'b1;
        nxt_ch = CH_W'(i);
      end
      if (mask_q[i]) lo_ch = CH_W'(i);
      if (ch_mask[i]) st_ch = CH_W'(i);
    end
  end
  // enable reaches one cycle into CS_SETUP so the first rise lands on the SHIFT entry edge
  assign sclk_en = (st == SHIFT && cnt != CNT_W'(SHIFT_CYC - 1)) ||
                   (st == CS_SETUP && cnt == CNT_W'(CLK_DIV - 1));
  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk (clk),
    .rst (rst),
    .en  (sclk_en),
    .sclk(adc_sclk),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      mask_q <= '0;
      ch <= '0;
      sr <= '0;
      rc <= '0;
      sh <= '0;
      adc_cs_n <= 1'b1;
      adc_mosi <= 1'b0;
      busy <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_ch <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      cnt <= cnt + 1'b1;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (fall) begin
        adc_mosi <= sr[CMD_W-1];
        sr <= sr << 1;
      end
      if (rise) begin
        rc <= rc + 1'b1;
        if (rc >= RC_W'(SKIP)) sh <= {sh[DATA_W-2:0], adc_miso};
      end
      case (st)
        IDLE:
          if (start && |ch_mask) begin
            mask_q <= ch_mask;
            ch <= st_ch;
            busy <= 1'b1;
            adc_cs_n <= 1'b0;
            adc_mosi <= CMD_START;
            sr <= cmd(st_ch) << 1;
            rc <= '0;
            cnt <= '0;
            st <= CS_SETUP;
          end
        CS_SETUP:
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            st <= SHIFT;
          end
        SHIFT:
          if (cnt == CNT_W'(SHIFT_CYC - 1)) begin
            cnt <= '0;
            st <= CS_HOLD;
          end
        CS_HOLD:
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt <= '0;
            adc_cs_n <= 1'b1;
            if (m_valid && !m_ready) overrun <= 1'b1;
            else begin
              m_valid <= 1'b1;
              m_data <= sh;
              m_ch <= ch;
            end
            ch <= nxt_found ? nxt_ch : lo_ch;
            busy <= nxt_found || cont;
            st <= (nxt_found || cont) ? GAP : IDLE;
          end
        GAP:
          if (cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            cnt <= '0;
            adc_cs_n <= 1'b0;
            adc_mosi <= CMD_START;
            sr <= cmd(ch) << 1;
            rc <= '0;
            st <= CS_SETUP;
          end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_spi_scanner.sv
// tb_adc_spi_scanner: scoreboard bench with a behavioural SPI ADC model driving directed scans
module tb_adc_spi_scanner;
  logic clk = 0, rst = 1, start = 0, cont = 0, m_ready = 1, adc_miso;
  logic [7:0] ch_mask = 0;
  logic adc_cs_n, adc_sclk, adc_mosi, busy, m_valid, overrun;
  logic [9:0] m_data;
  logic [2:0] m_ch;
  int total = 0, bad = 0, got = 0, rises = 0, ov_cnt = 0, cs_falls = 0;
  int nr = 0, nf = 0, mosi_bad = 0, n, r0, g0, c0, ov0;
  logic [4:0] cmd_cap = 0;
  logic [9:0] vals[8];
  logic [12:0] exp_q[$];
  logic [12:0] e;
  time fall_t[$];

  always #5 clk = ~clk;

  adc_spi_scanner dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_mask(ch_mask),
    .adc_miso(adc_miso), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi),
    .busy(busy), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
    .overrun(overrun)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge adc_cs_n) begin
    nr = 0;
    nf = 0;
    mosi_bad = 0;
    cs_falls++;
    fall_t.push_back($time);
  end
  always @(posedge adc_sclk) begin
    rises++;
    if (nr < 5) cmd_cap = {cmd_cap[3:0], adc_mosi};
    else if (adc_mosi) mosi_bad++;
    nr++;
  end
  always @(negedge adc_sclk) nf++;
  assign adc_miso = (!adc_cs_n && nf >= 8 && nf < 18) ? vals[cmd_cap[2:0]][17-nf] : 1'b0;

  always @(posedge adc_cs_n)
    if (!rst) begin
      chk("frame_sclk_rises", nr, 18);
      chk("frame_cmd_prefix", int'(cmd_cap[4:3]), 3);
      chk("frame_mosi_tail", mosi_bad, 0);
    end

  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (m_valid && m_ready) begin
      got++;
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("result_ch", int'(m_ch), int'(e[12:10]));
        chk("result_data", int'(m_data), int'(e[9:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask
  task automatic push(input logic [2:0] c, input logic [9:0] d);
    exp_q.push_back({c, d});
  endtask
  task automatic do_start(input logic [7:0] m);
    @(negedge clk);
    ch_mask = m;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_idle(input int lim, output int cnt);
    cnt = 0;
    while (busy && cnt < lim) begin
      tick();
      cnt++;
    end
    chk("wait_busy_low", int'(busy), 0);
  endtask
  task automatic wait_got(input int tgt, input int lim);
    int k = 0;
    while (got < tgt && k < lim) begin
      tick();
      k++;
    end
    chk("wait_results", int'(got >= tgt), 1);
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cs_n"}, int'(adc_cs_n), 1);
    chk({nm, "_sclk"}, int'(adc_sclk), 0);
    chk({nm, "_mosi"}, int'(adc_mosi), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_m_valid"}, int'(m_valid), 0);
    chk({nm, "_m_data"}, int'(m_data), 0);
    chk({nm, "_m_ch"}, int'(m_ch), 0);
    chk({nm, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) vals[i] = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    tick();
    chk_reset_outputs("reset");

    // single channel, single shot
    vals[0] = 50;
    push(0, 50);
    r0 = rises;
    g0 = got;
    do_start(8'b0000_0001);
    chk("t1_busy_up", int'(busy), 1);
    chk("t1_cs_low", int'(adc_cs_n), 0);
    wait_idle(400, n);
    chk("t1_latency", n, 152);
    chk("t1_rises", rises - r0, 18);
    chk("t1_cmd", int'(cmd_cap), 24);
    tick();
    chk("t1_results", got, g0 + 1);

    // sparse mask, ascending order, frame spacing
    vals[2] = 1023;
    vals[5] = 0;
    vals[7] = 512;
    push(2, 1023);
    push(5, 0);
    push(7, 512);
    fall_t.delete();
    g0 = got;
    do_start(8'b1010_0100);
    wait_idle(700, n);
    chk("t2_duration", n, 472);
    tick();
    chk("t2_results", got, g0 + 3);
    chk("t2_frames", fall_t.size(), 3);
    if (fall_t.size() >= 3) begin
      chk("t2_spacing01", int'(fall_t[1] - fall_t[0]), 1600);
      chk("t2_spacing12", int'(fall_t[2] - fall_t[1]), 1600);
    end

    // continuous mode, dropped after the third result
    vals[0] = 11;
    vals[1] = 22;
    push(0, 11);
    push(1, 22);
    push(0, 11);
    push(1, 22);
    g0 = got;
    cont = 1;
    do_start(8'b0000_0011);
    wait_got(g0 + 3, 700);
    cont = 0;
    wait_idle(700, n);
    tick();
    chk("t3_results", got, g0 + 4);
    repeat (400) tick();
    chk("t3_stopped_results", got, g0 + 4);
    chk("t3_stopped_cs", int'(adc_cs_n), 1);
    chk("t3_stopped_busy", int'(busy), 0);

    // backpressure: second result dropped with one overrun pulse
    vals[0] = 100;
    vals[1] = 200;
    push(0, 100);
    g0 = got;
    ov0 = ov_cnt;
    tick();
    m_ready = 0;
    do_start(8'b0000_0011);
    wait_idle(500, n);
    tick();
    chk("t4_overruns", ov_cnt - ov0, 1);
    chk("t4_held_valid", int'(m_valid), 1);
    chk("t4_held_data", int'(m_data), 100);
    chk("t4_held_ch", int'(m_ch), 0);
    chk("t4_no_accept", got, g0);
    tick();
    m_ready = 1;
    tick();
    chk("t4_valid_drop", int'(m_valid), 0);
    chk("t4_results", got, g0 + 1);

    // reset in the middle of a frame, then a clean frame
    vals[0] = 77;
    r0 = rises;
    g0 = got;
    do_start(8'b0000_0001);
    n = 0;
    while (rises < r0 + 9 && n < 300) begin
      tick();
      n++;
    end
    chk("t5_rise9", rises - r0, 9);
    rst = 1;
    #1;
    chk_reset_outputs("t5_reset");
    tick();
    tick();
    rst = 0;
    repeat (200) tick();
    chk("t5_no_result", got, g0);
    chk("t5_no_valid", int'(m_valid), 0);
    push(0, 77);
    do_start(8'b0000_0001);
    wait_idle(400, n);
    chk("t5_latency", n, 152);
    tick();
    chk("t5_results", got, g0 + 1);

    // ignored starts: empty mask, and start while busy
    c0 = cs_falls;
    do_start(8'h00);
    chk("t6_mask0_busy", int'(busy), 0);
    chk("t6_mask0_cs", int'(adc_cs_n), 1);
    repeat (30) tick();
    chk("t6_mask0_frames", cs_falls, c0);
    vals[3] = 333;
    push(3, 333);
    g0 = got;
    do_start(8'b0000_1000);
    repeat (20) tick();
    do_start(8'hFF);
    chk("t6_still_busy", int'(busy), 1);
    wait_idle(400, n);
    tick();
    chk("t6_results", got, g0 + 1);
    chk("t6_frames", cs_falls, c0 + 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
